// File: rtl/reg8_arbiter.sv
// Round-robin front end for one shared load/increment register: grants a single
// requester, drives ld/inc/in for one cycle, then acks with the updated value.
module reg8_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   op,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   rdata,
    output logic           wrap,
    output logic           busy,
    output logic           reg_ld,
    output logic           reg_inc,
    output logic [W-1:0]   reg_in,
    input  logic [W-1:0]   reg_out
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic            op_q, op_d;
    logic [W-1:0]    data_q, data_d;
    logic            wrap_pend_q, wrap_pend_d;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [N-1:0]    win_oh;
    logic [W-1:0]    wdata_a [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign wdata_a[gi] = wdata[gi*W +: W];
            assign win_oh[gi]  = (win_q == IW'(gi));
        end
    endgenerate

    // Scan downward in distance so the closest set bit after the pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        for (int k = N; k >= 1; k--) begin
            logic [IW-1:0] idx;
            idx = IW'((int'(ptr_q) + k) % N);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_vld) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= IW'(N - 1);
            win_q       <= '0;
            op_q        <= 1'b0;
            data_q      <= '0;
            wrap_pend_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            op_q        <= op_d;
            data_q      <= data_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        win_d       = win_q;
        op_d        = op_q;
        data_d      = data_q;
        wrap_pend_d = wrap_pend_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    win_d  = pick;
                    op_d   = op[pick];
                    data_d = wdata_a[pick];
                end
            end
            // reg_out still holds the pre-update value during EXEC.
            S_EXEC:  wrap_pend_d = !op_q && (reg_out == {W{1'b1}});
            S_DONE:  ptr_d = win_q;
            default: ;
        endcase
    end

    always_comb begin
        gnt     = '0;
        ack     = '0;
        rdata   = '0;
        wrap    = 1'b0;
        busy    = (state_q != S_IDLE);
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_in  = '0;
        case (state_q)
            S_EXEC: begin
                gnt     = win_oh;
                reg_ld  = op_q;
                reg_inc = !op_q;
                reg_in  = data_q;
            end
            S_DONE: begin
                gnt   = win_oh;
                ack   = win_oh;
                rdata = reg_out;
                wrap  = wrap_pend_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg8_arbiter.sv
// Bench for reg8_arbiter: bench-side register, transaction-level model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_reg8_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   op = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [W-1:0]   rdata, reg_in, reg_out;
    logic           wrap, busy, reg_ld, reg_inc;
    logic [W-1:0]   ext_reg = '0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    reg8_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .wrap(wrap), .busy(busy),
        .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_in(reg_in), .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    // The shared register: ld has priority over inc, own (absent) reset.
    assign reg_out = ext_reg;
    always @(posedge clk) begin
        if (reg_ld)       ext_reg <= reg_in;
        else if (reg_inc) ext_reg <= ext_reg + 8'd1;
    end

    // Transaction model: cycles elapsed since a request was accepted.
    int         m_phase = 0;
    int         m_ptr = N - 1;
    int         m_win = 0;
    bit         m_op = 1'b0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_reg = '0;
    bit         m_wrap = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_ptr   = N - 1;
        end else begin
            if (m_phase == 0) begin
                if (req != 0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (req[(m_ptr + k) % N]) begin
                            m_win = (m_ptr + k) % N;
                            break;
                        end
                    end
                    m_op    = op[m_win];
                    m_data  = wdata[m_win*W +: W];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_wrap  = !m_op && (m_reg == 8'hFF);
                m_reg   = m_op ? m_data : m_reg + 8'd1;
                m_phase = 2;
            end else begin
                m_ptr   = m_win;
                m_phase = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] e_oh;
            e_oh = (m_phase != 0) ? N'(1 << m_win) : '0;
            chk("gnt",     gnt,     e_oh);
            chk("ack",     ack,     (m_phase == 2) ? e_oh : '0);
            chk("rdata",   rdata,   (m_phase == 2) ? m_reg : '0);
            chk("wrap",    wrap,    (m_phase == 2) ? m_wrap : 1'b0);
            chk("busy",    busy,    m_phase != 0);
            chk("reg_ld",  reg_ld,  (m_phase == 1) && m_op);
            chk("reg_inc", reg_inc, (m_phase == 1) && !m_op);
            chk("reg_in",  reg_in,  (m_phase == 1) ? m_data : '0);
            if (ack != 0)
                $display("txn requester=%0d op=%0b rdata=%02h wrap=%0b t=%0t",
                         oh2i(ack), m_op, rdata, wrap, $time);
        end
    end

    int           col_n;
    int           col_idx [8];
    logic [W-1:0] col_rd [8];
    logic         col_wr [8];
    int           col_t [8];

    task automatic collect(input int nexp, input bit hold);
        int cyc;
        cyc   = 0;
        col_n = 0;
        while (col_n < nexp && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack != 0) begin
                col_idx[col_n] = oh2i(ack);
                col_rd[col_n]  = rdata;
                col_wr[col_n]  = wrap;
                col_t[col_n]   = cyc;
                if (!hold) req[oh2i(ack)] = 1'b0;
                col_n++;
                if (col_n == nexp) req = '0;
            end
        end
        chk("collect_count", col_n, nexp);
        req = '0;
    endtask

    task automatic wait_ack(input int i, output logic [W-1:0] rd, output logic wr, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack[i] && lat < 40);
        chk("ack_timeout", ack[i], 1'b1);
        rd = rdata;
        wr = wrap;
    endtask

    task automatic do_op(input int i, input bit o, input logic [W-1:0] d,
                         output logic [W-1:0] rd, output logic wr, output int lat);
        op[i] = o;
        wdata[i*W +: W] = d;
        req[i] = 1'b1;
        wait_ack(i, rd, wr, lat);
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        logic         wr;
        int           lat;

        #2 rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", gnt, '0);
        chk("rst_reg_in", reg_in, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Load 0x5A through requester 0.
        do_op(0, 1'b1, 8'h5A, rd, wr, lat);
        chk("t1_rdata", rd, 8'h5A);
        chk("t1_wrap", wr, 1'b0);
        chk("t1_latency", lat, 2);

        // Increment across 0xFF.
        do_op(2, 1'b1, 8'hFE, rd, wr, lat);
        do_op(2, 1'b0, 8'h00, rd, wr, lat);
        chk("t2_rdata_ff", rd, 8'hFF);
        chk("t2_wrap0", wr, 1'b0);
        do_op(2, 1'b0, 8'h00, rd, wr, lat);
        chk("t2_rdata_00", rd, 8'h00);
        chk("t2_wrap1", wr, 1'b1);

        // Rotation with all requests held, pointer at 3, register at 0.
        do_op(3, 1'b1, 8'h00, rd, wr, lat);
        op  = '0;
        req = '1;
        collect(5, 1'b1);
        for (int j = 0; j < 5; j++) begin
            chk("t3_order", col_idx[j], j % 4);
            chk("t3_rdata", col_rd[j], j + 1);
            if (j > 0) chk("t3_spacing", col_t[j] - col_t[j-1], 3);
        end
        @(negedge clk);

        // Pointer at 1: requester 3 beats requester 1.
        do_op(1, 1'b1, 8'h00, rd, wr, lat);
        op[1] = 1'b1; wdata[1*W +: W] = 8'h10;
        op[3] = 1'b1; wdata[3*W +: W] = 8'h30;
        req[1] = 1'b1; req[3] = 1'b1;
        collect(2, 1'b0);
        chk("t4_first", col_idx[0], 3);
        chk("t4_first_rd", col_rd[0], 8'h30);
        chk("t4_second", col_idx[1], 1);
        chk("t4_second_rd", col_rd[1], 8'h10);
        @(negedge clk);

        // Single-cycle request pulse still completes.
        op[0] = 1'b0;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        wait_ack(0, rd, wr, lat);
        chk("t5_rdata", rd, 8'h11);
        chk("t5_latency", lat, 1);
        @(negedge clk);

        // Reset during EXEC aborts the operation.
        op[0] = 1'b1; wdata[0*W +: W] = 8'h77;
        req[0] = 1'b1;
        @(posedge clk);
        #1 chk("t6_exec_ld", reg_ld, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("t6_gnt", gnt, '0);
        chk("t6_ld", reg_ld, 1'b0);
        chk("t6_inc", reg_inc, 1'b0);
        chk("t6_busy", busy, 1'b0);
        req[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t6_noack", ack, '0);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        op[0] = 1'b0; op[1] = 1'b0;
        req[0] = 1'b1; req[1] = 1'b1;
        collect(2, 1'b0);
        chk("t6_first", col_idx[0], 0);
        chk("t6_first_rd", col_rd[0], 8'h12);
        chk("t6_second", col_idx[1], 1);
        chk("t6_second_rd", col_rd[1], 8'h13);
        @(negedge clk);

        // Random traffic, biased toward loads near the wrap point.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    op[i] = 1'($urandom_range(0, 1));
                    wdata[i*W +: W] = ($urandom_range(0, 1) == 1) ?
                        8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        begin
            int d;
            d = 0;
            while (req != 0 && d < 100) begin
                @(negedge clk);
                d++;
                for (int i = 0; i < N; i++) if (ack[i]) req[i] = 1'b0;
            end
            chk("drain_timeout", {31'd0, req == 0}, 32'd1);
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
